// File: rtl/io_po_pdc_ecb1_dchain_tx.sv
// Fabric-to-pad data-chain transmit cell: direct registered output, or a chain word framed as start/data/stop.
// Build option IO_PO_PDC_ECB1_PARITY_EN inserts an even-parity bit between data and stop.
module io_po_pdc_ecb1_dchain_tx #(
  parameter int CHAIN_W = 8,
  parameter int CFG_W   = 13
) (
  input  logic             io_po_pdc_ecb1_clk,
  input  logic             io_po_pdc_ecb1_reset,
  input  logic             SE0,
  input  logic             SE1,
  input  logic             SR,
  input  logic [0:CFG_W-1] feedthrough_mem_in,
  input  logic             io_po_pdc_ecb1_f2a_i,
  input  logic             io_po_pdc_ecb1_sc_in,
  output logic             io_po_pdc_ecb1_sc_out,
  output logic             io_po_pdc_ecb1_busy,
  output logic             io_po_pdc_ecb1_ovr,
  output logic             gfpga_pad_poutput_dchain_extmode_F2A,
  output logic             gfpga_pad_poutput_dchain_extmode_oe,
  output logic             gfpga_pad_poutput_dchain_extmode_mode_o
);

  localparam int CNT_W = (CHAIN_W > 1) ? $clog2(CHAIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_W - 1);

`ifdef IO_PO_PDC_ECB1_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CHAIN_W-1:0] shift_q, hold_q, pend_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_v_q, ovr_q, se1_q, dir_q;
  logic               chain_mode, upd, tx_bit;
  logic               cfg_unused;

  assign chain_mode = feedthrough_mem_in[0];
  assign upd        = SE1 & ~se1_q & chain_mode;
  assign cfg_unused = ^feedthrough_mem_in[3:CFG_W-1];

  always_ff @(posedge io_po_pdc_ecb1_clk or posedge io_po_pdc_ecb1_reset) begin
    if (io_po_pdc_ecb1_reset) state_q <= IDLE;
    else                      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (SR || !chain_mode) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (upd) state_d = START;
        START: state_d = DATA;
`ifdef IO_PO_PDC_ECB1_PARITY_EN
        DATA:  if (cnt_q == CNT_LAST) state_d = PAR;
        PAR:   state_d = STOP;
`else
        DATA:  if (cnt_q == CNT_LAST) state_d = STOP;
`endif
        // An update landing on STOP with nothing pending starts the next frame directly.
        STOP:  state_d = (pend_v_q || upd) ? START : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_bit = 1'b0;
    if (!chain_mode) begin
      tx_bit = dir_q;
    end else begin
      case (state_q)
        START:   tx_bit = 1'b1;
        DATA:    tx_bit = hold_q[cnt_q];
`ifdef IO_PO_PDC_ECB1_PARITY_EN
        PAR:     tx_bit = ^hold_q;
`endif
        default: tx_bit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge io_po_pdc_ecb1_clk or posedge io_po_pdc_ecb1_reset) begin
    if (io_po_pdc_ecb1_reset) begin
      shift_q  <= '0;
      hold_q   <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      se1_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      se1_q <= SE1;
      dir_q <= SR ? 1'b0 : io_po_pdc_ecb1_f2a_i;
      if (SR) begin
        shift_q  <= '0;
        hold_q   <= '0;
        pend_q   <= '0;
        cnt_q    <= '0;
        pend_v_q <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (SE0) shift_q <= {shift_q[CHAIN_W-2:0], io_po_pdc_ecb1_sc_in};
        if (!chain_mode) begin
          pend_v_q <= 1'b0;
        end else begin
          case (state_q)
            IDLE:  if (upd) hold_q <= shift_q;
            START: cnt_q <= '0;
            DATA:  if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
            STOP: begin
              // Pending word is consumed before a same-cycle update refills pend.
              if (pend_v_q) begin
                hold_q   <= pend_q;
                pend_v_q <= upd;
                if (upd) pend_q <= shift_q;
              end else if (upd) begin
                hold_q <= shift_q;
              end
            end
            default: ;
          endcase
          if (upd && state_q != IDLE && state_q != STOP) begin
            ovr_q    <= ovr_q | pend_v_q;
            pend_q   <= shift_q;
            pend_v_q <= 1'b1;
          end
        end
      end
    end
  end

  assign io_po_pdc_ecb1_sc_out                   = shift_q[CHAIN_W-1];
  assign io_po_pdc_ecb1_busy                     = (state_q != IDLE) | pend_v_q;
  assign io_po_pdc_ecb1_ovr                      = ovr_q;
  assign gfpga_pad_poutput_dchain_extmode_F2A    = tx_bit ^ feedthrough_mem_in[2];
  assign gfpga_pad_poutput_dchain_extmode_oe     = feedthrough_mem_in[1];
  assign gfpga_pad_poutput_dchain_extmode_mode_o = feedthrough_mem_in[0];

endmodule
